vga_timing_gen: RTL

- Parametrised VGA raster timing generator and pixel-output stage.
- Drives pixel-request coordinates toward the frame buffer and accepts returned pixel data after a fixed read latency.
- Emits colour, Hsync, Vsync and data-enable, all aligned to each other.
- Replaces the fixed 640x480 generator and supports any mode, colour depth, sync polarity and frame-buffer latency.

---
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a pixel-latency-matched output stage.
// Optional macro VGA_TESTPAT_EN adds a testpat input that swaps pixel_in for 8 vertical colour bars.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int R_BITS   = 3,
  parameter int G_BITS   = 3,
  parameter int B_BITS   = 2,
  parameter int PIX_LAT  = 1
) (
  input  logic                              CLK25MHz,
  input  logic                              RST,
  input  logic                              EN,
`ifdef VGA_TESTPAT_EN
  input  logic                              testpat,
`endif
  input  logic [R_BITS+G_BITS+B_BITS-1:0]   pixel_in,
  output logic [10:0]                       XCoord,
  output logic [10:0]                       YCoord,
  output logic                              req_active,
  output logic                              Hsync,
  output logic                              Vsync,
  output logic                              de,
  output logic [R_BITS-1:0]                 R,
  output logic [G_BITS-1:0]                 G,
  output logic [B_BITS-1:0]                 B,
  output logic                              frame_start,
  output logic                              line_start
);

  localparam int PW      = R_BITS + G_BITS + B_BITS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 12-bit thresholds so a sync edge landing exactly on 2048 still compares correctly
  localparam logic [11:0] H_ACT_T  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG_T = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_T = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_T  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG_T = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_T = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
`ifdef VGA_TESTPAT_EN
    logic [10:0] x;
`endif
  } stage_t;

  logic [10:0]   hcnt;
  logic [10:0]   vcnt;
  logic          hs_raw;
  logic          vs_raw;
  stage_t        raw_stage;
  stage_t        load_stage;
  logic [PW-1:0] colour;

  always_ff @(posedge CLK25MHz) begin
    if (RST) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (EN) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 11'd1;
      end else begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

  assign XCoord      = hcnt;
  assign YCoord      = vcnt;
  assign req_active  = ({1'b0, hcnt} < H_ACT_T) && ({1'b0, vcnt} < V_ACT_T);
  assign hs_raw      = ({1'b0, hcnt} >= HS_BEG_T) && ({1'b0, hcnt} < HS_END_T);
  assign vs_raw      = ({1'b0, vcnt} >= VS_BEG_T) && ({1'b0, vcnt} < VS_END_T);
  assign frame_start = EN && (hcnt == 11'd0) && (vcnt == 11'd0);
  assign line_start  = EN && (hcnt == 11'd0);

  always_comb begin
    raw_stage     = '0;
    raw_stage.act = req_active;
    raw_stage.hs  = hs_raw;
    raw_stage.vs  = vs_raw;
`ifdef VGA_TESTPAT_EN
    raw_stage.x   = hcnt;
`endif
  end

  // PIX_LAT stages here plus the output register give the full PIX_LAT+1 alignment
  generate
    if (PIX_LAT == 0) begin : g_no_delay
      assign load_stage = raw_stage;
    end else begin : g_delay
      stage_t pipe [PIX_LAT];

      always_ff @(posedge CLK25MHz) begin
        if (RST) begin
          for (int i = 0; i < PIX_LAT; i++) pipe[i] <= '0;
        end else if (EN) begin
          pipe[0] <= raw_stage;
          for (int i = 1; i < PIX_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign load_stage = pipe[PIX_LAT-1];
    end
  endgenerate

`ifdef VGA_TESTPAT_EN
  localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] BAR_W_C = 11'(BAR_W);

  logic [10:0] bar_q;
  logic [2:0]  bar;

  always_comb begin
    bar_q  = load_stage.x / BAR_W_C;
    bar    = (bar_q < 11'd7) ? bar_q[2:0] : 3'd7;
    colour = pixel_in;
    if (testpat) begin
      colour = {{R_BITS{bar[2]}}, {G_BITS{bar[1]}}, {B_BITS{bar[0]}}};
    end
  end
`else
  always_comb begin
    colour = pixel_in;
  end
`endif

  // Output register: sync polarity applied here so Hsync/Vsync come straight off flops
  always_ff @(posedge CLK25MHz) begin
    if (RST) begin
      Hsync     <= ~H_POL;
      Vsync     <= ~V_POL;
      de        <= 1'b0;
      {R, G, B} <= '0;
    end else if (EN) begin
      Hsync     <= load_stage.hs ? H_POL : ~H_POL;
      Vsync     <= load_stage.vs ? V_POL : ~V_POL;
      de        <= load_stage.act;
      {R, G, B} <= load_stage.act ? colour : '0;
    end
  end

endmodule
